battle_launcher: RTL and testbench
==================================

Name: battle_launcher

Overview:
- Initiator-side controller for the battle engine. Runs the title screen and 3-of-8 team selection from keyboard keycodes.
- Drives the engine's is_battle/team inputs and holds them stable for the whole battle.
- Consumes the engine's end_battle/result, then shows a result screen and keeps win-streak statistics.
- Sits between the keyboard keycode source and the battle engine, at the top game level.

Parameters:
NUM_SPECIES, 8, number of selectable species; ids 0..NUM_SPECIES-1 (3-bit)
TEAM_SIZE, 3, picks per team
STREAK_W, 8, width of streak counters

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
keycode  in  8  current USB keycode; 0x00 = no key
end_battle  in  1  one-cycle pulse from battle engine at Win/Lose
result  in  1  valid with end_battle; 1 = win, 0 = loss
is_battle  out  1  battle request/active level to engine
team  out  [2:0][2:0]  selected species ids, slot 0 leads
screen  out  2  0 TITLE, 1 SELECT, 2 BATTLE, 3 RESULT (for renderer)
cursor  out  3  hovered species id in SELECT
picked_mask  out  8  bit i = species i already on team
slot_count  out  2  picks made (0..3)
last_result  out  1  latched result of last battle
win_streak  out  STREAK_W  consecutive wins
best_streak  out  STREAK_W  maximum win_streak since reset

Behaviour:
- Reset (async, Reset_n=0):
  - All outputs 0; state TITLE; prev_key 0.
  - is_battle drops immediately, including mid-battle.
- Key events:
  - prev_key is a register updated every cycle.
  - press = (keycode != prev_key) && (keycode != 0).
  - Held keys produce exactly one event. Repeating the same key needs a release (0x00) or a different key in between.
  - Keycodes used: W 0x1A, A 0x04, S 0x16, D 0x07, ENTER 0x28, BKSP 0x2A. All others are ignored.
  - An event is acted on in the cycle it is detected; its effect is visible on outputs the next cycle.
- States:
  - TITLE:
    - ENTER press -> SELECT.
    - On entry: cursor=0, slot_count=0, picked_mask=0, team=0.
  - SELECT (grid of 2 rows x 4 cols; cursor = row*4+col):
    - W: cursor-=4 if cursor>=4.
    - S: cursor+=4 if cursor<4.
    - A: cursor-=1 if col!=0.
    - D: cursor+=1 if col!=3.
    - No wrap-around; moves at an edge are no-ops.
    - ENTER:
      - If picked_mask[cursor]=0: team[slot_count]=cursor, set mask bit, slot_count++.
      - If the species is already picked: no change.
      - When slot_count becomes 3 -> CONFIRM.
    - BKSP:
      - If slot_count>0: slot_count--, clear mask bit of team[slot_count], team[slot_count]=0.
      - At slot_count 0: BKSP -> TITLE.
  - CONFIRM:
    - ENTER -> BATTLE.
    - BKSP -> SELECT, removing the last pick (slot_count 3->2).
  - BATTLE:
    - is_battle=1 (registered, asserted the cycle after entry).
    - team, mask and cursor are frozen; all key events are ignored.
    - On end_battle=1: latch last_result=result, update streaks, is_battle=0 on the next cycle -> RESULT.
    - is_battle must be low before the engine returns to its idle state so it does not relaunch.
  - RESULT:
    - ENTER press -> TITLE, which clears the team.
    - end_battle is ignored.
- Streaks:
  - Win: win_streak+1, saturating at all-ones.
  - Loss: win_streak=0.
  - best_streak = max(best_streak, new win_streak), updated in the same cycle.
- Simultaneous events:
  - end_battle is honoured only in BATTLE; pulses in any other state are ignored.
  - In BATTLE, a key event in the same cycle as end_battle is discarded.
  - Only one key event can exist per cycle, so no key priority rule is needed.

Decomposition:
- Shared package battle_pkg holds:
  - keycode constants W/A/S/D/ENTER/BKSP (shared with the battle engine);
  - screen_t enum {TITLE, SELECT, BATTLE, RESULT};
  - species id typedef logic [2:0].
- Internal CONFIRM is a substate that reports screen=SELECT.
- One sub-module: key_edge (prev_key register + press detect, outputs press and key).

Test Plan:
- Reset mid-battle:
  - Stimulus: drive Reset_n=0 while in BATTLE.
  - Required: is_battle=0 within the same cycle, with no clock edge needed; after release, screen=0, all counters 0.
- Held key:
  - Stimulus: ENTER in TITLE, held for 10 cycles.
  - Required: exactly one transition to SELECT; a second ENTER without release adds no pick.
- Full selection:
  - Stimulus: from SELECT, press D,D,ENTER,S,ENTER,A,ENTER,ENTER.
  - Required: team={2,6,5}, picked_mask=0x64, slot_count=3, then is_battle=1 the cycle after CONFIRM ENTER.
- Edges and duplicates:
  - Stimulus: W at cursor 1; A at cursor 4; ENTER on an already-picked species.
  - Required: cursor unchanged in each case; mask and slot_count unchanged.
- End of battle:
  - Stimulus: end_battle=1, result=1 in three successive battles, then a loss.
  - Required: win_streak 1,2,3,0; best_streak=3; last_result=0; is_battle low 1 cycle after each pulse.
- Stray pulse and BKSP unwind:
  - Stimulus: end_battle pulse in SELECT; then BKSP x4 from slot_count=3.
  - Required: pulse ignored; mask clears in reverse pick order; 4th BKSP returns to TITLE.

Source files
------------

// File: rtl/battle_pkg.sv
// Shared definitions for the battle launcher and the battle engine:
// keycodes, renderer screen codes and species/team types.
package battle_pkg;
  localparam int NUM_SPECIES = 8;
  localparam int TEAM_SIZE   = 3;
  localparam int STREAK_W    = 8;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_BKSP  = 8'h2A;

  typedef enum logic [1:0] {TITLE = 2'd0, SELECT = 2'd1, BATTLE = 2'd2, RESULT = 2'd3} screen_t;
  typedef logic [2:0] species_t;
  typedef species_t [TEAM_SIZE-1:0] team_t;
endpackage

// File: rtl/battle_launcher_if.sv
// Launcher-side bundle: keyboard input, engine handshake and renderer/status outputs.
interface battle_launcher_if;
  import battle_pkg::*;
  logic [7:0]             keycode;
  logic                   end_battle;
  logic                   result;
  logic                   is_battle;
  team_t                  team;
  logic [1:0]             screen;
  species_t               cursor;
  logic [NUM_SPECIES-1:0] picked_mask;
  logic [1:0]             slot_count;
  logic                   last_result;
  logic [STREAK_W-1:0]    win_streak;
  logic [STREAK_W-1:0]    best_streak;

  modport master (
    input  keycode, end_battle, result,
    output is_battle, team, screen, cursor, picked_mask, slot_count,
           last_result, win_streak, best_streak
  );
  modport slave (
    output keycode, end_battle, result,
    input  is_battle, team, screen, cursor, picked_mask, slot_count,
           last_result, win_streak, best_streak
  );
endinterface

// File: rtl/battle_launcher_key_edge.sv
// Turns a level keycode into one press event per new non-zero key.
module key_edge (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] keycode,
  output logic       press,
  output logic [7:0] key
);
  logic [7:0] prev_key;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) prev_key <= '0;
    else          prev_key <= keycode;
  end

  assign press = (keycode != prev_key) && (keycode != 8'h00);
  assign key   = keycode;
endmodule

// File: rtl/battle_launcher.sv
// Title / team-select / battle / result controller in front of the battle engine.
module battle_launcher
  import battle_pkg::*;
(
  input  logic         Clk,
  input  logic         Reset_n,
  battle_launcher_if.master bus
);
  typedef enum logic [2:0] {ST_TITLE, ST_SELECT, ST_CONFIRM, ST_BATTLE, ST_RESULT} state_t;

  state_t                 state, state_n;
  species_t               cursor, cursor_n;
  logic [NUM_SPECIES-1:0] mask, mask_n;
  logic [1:0]             slot, slot_n, slot_last;
  team_t                  team, team_n;
  logic                   is_battle, is_battle_n, last, last_n, drop_last;
  logic [STREAK_W-1:0]    ws, ws_n, ws_inc, best, best_n;
  logic                   press;
  logic [7:0]             key;

  key_edge u_key (.Clk(Clk), .Reset_n(Reset_n), .keycode(bus.keycode), .press(press), .key(key));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= ST_TITLE; cursor <= '0; mask <= '0; slot <= '0; team <= '0;
      is_battle <= 1'b0; last <= 1'b0; ws <= '0; best <= '0;
    end else begin
      state <= state_n; cursor <= cursor_n; mask <= mask_n; slot <= slot_n; team <= team_n;
      is_battle <= is_battle_n; last <= last_n; ws <= ws_n; best <= best_n;
    end
  end

  assign slot_last = slot - 2'd1;
  assign ws_inc    = (ws == {STREAK_W{1'b1}}) ? ws : ws + 1'b1;

  always_comb begin
    state_n = state; cursor_n = cursor; mask_n = mask; slot_n = slot; team_n = team;
    last_n = last; ws_n = ws; best_n = best; drop_last = 1'b0;
    case (state)
      ST_TITLE:  if (press && key == KEY_ENTER) state_n = ST_SELECT;
      ST_SELECT: if (press) begin
        // 2x4 grid: cursor[2] is the row, cursor[1:0] the column
        case (key)
          KEY_W: if (cursor[2])          cursor_n = {1'b0, cursor[1:0]};
          KEY_S: if (!cursor[2])         cursor_n = {1'b1, cursor[1:0]};
          KEY_A: if (cursor[1:0] != 2'd0) cursor_n = cursor - 3'd1;
          KEY_D: if (cursor[1:0] != 2'd3) cursor_n = cursor + 3'd1;
          KEY_ENTER: if (!mask[cursor]) begin
            team_n[slot]   = cursor;
            mask_n[cursor] = 1'b1;
            slot_n         = slot + 2'd1;
            if (slot == 2'(TEAM_SIZE - 1)) state_n = ST_CONFIRM;
          end
          KEY_BKSP: if (slot != 2'd0) drop_last = 1'b1;
                    else              state_n   = ST_TITLE;
          default: ;
        endcase
      end
      ST_CONFIRM: if (press) begin
        if (key == KEY_ENTER)     state_n = ST_BATTLE;
        else if (key == KEY_BKSP) begin
          drop_last = 1'b1;
          state_n   = ST_SELECT;
        end
      end
      // keys are ignored here, so a key in the end_battle cycle is dropped
      ST_BATTLE: if (bus.end_battle) begin
        state_n = ST_RESULT;
        last_n  = bus.result;
        ws_n    = bus.result ? ws_inc : '0;
        best_n  = (ws_n > best) ? ws_n : best;
      end
      ST_RESULT: if (press && key == KEY_ENTER) state_n = ST_TITLE;
      default:   state_n = ST_TITLE;
    endcase

    if (drop_last) begin
      slot_n                = slot_last;
      mask_n[team[slot_last]] = 1'b0;
      team_n[slot_last]     = '0;
    end
    // every arrival in (or stay in) TITLE starts from an empty team
    if (state_n == ST_TITLE) begin
      cursor_n = '0; mask_n = '0; slot_n = '0; team_n = '0;
    end
    is_battle_n = (state_n == ST_BATTLE);
  end

  always_comb begin
    case (state)
      ST_SELECT, ST_CONFIRM: bus.screen = SELECT;
      ST_BATTLE:             bus.screen = BATTLE;
      ST_RESULT:             bus.screen = RESULT;
      default:               bus.screen = TITLE;
    endcase
  end

  assign bus.is_battle   = is_battle;
  assign bus.team        = team;
  assign bus.cursor      = cursor;
  assign bus.picked_mask = mask;
  assign bus.slot_count  = slot;
  assign bus.last_result = last;
  assign bus.win_streak  = ws;
  assign bus.best_streak = best;
endmodule

// File: tb/tb_battle_launcher.sv
// Bench for battle_launcher: directed table, corner sequences and a random run
// against a queue-based model of the launcher's rules.
module tb_battle_launcher;
  import battle_pkg::*;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  battle_launcher_if bus();
  battle_launcher dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));
  always #5 Clk = ~Clk;

  int n_cmp = 0, n_bad = 0;

  // model: 0 TITLE, 1 SELECT, 2 CONFIRM, 3 BATTLE, 4 RESULT
  int m_st, m_cur, m_prev, m_last, m_ws, m_best;
  int m_q[$];

  typedef struct {
    logic [7:0] kc;
    int scr, cur, mask, slot, isb;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_st = 0; m_cur = 0; m_prev = 0; m_last = 0; m_ws = 0; m_best = 0;
    m_q.delete();
  endfunction

  function automatic bit picked(int s);
    foreach (m_q[i]) if (m_q[i] == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_step(int kc, int eb, int res);
    bit p = (kc != m_prev) && (kc != 0);
    m_prev = kc;
    case (m_st)
      0: if (p && kc == KEY_ENTER) m_st = 1;
      1: if (p) begin
        if (kc == KEY_W && m_cur >= 4) m_cur -= 4;
        else if (kc == KEY_S && m_cur < 4) m_cur += 4;
        else if (kc == KEY_A && m_cur % 4 != 0) m_cur -= 1;
        else if (kc == KEY_D && m_cur % 4 != 3) m_cur += 1;
        else if (kc == KEY_ENTER && !picked(m_cur)) begin
          m_q.push_back(m_cur);
          if (m_q.size() == 3) m_st = 2;
        end else if (kc == KEY_BKSP) begin
          if (m_q.size() > 0) void'(m_q.pop_back());
          else m_st = 0;
        end
      end
      2: if (p && kc == KEY_ENTER) m_st = 3;
         else if (p && kc == KEY_BKSP) begin void'(m_q.pop_back()); m_st = 1; end
      3: if (eb != 0) begin
        m_last = res;
        m_ws   = res ? ((m_ws < 255) ? m_ws + 1 : 255) : 0;
        if (m_ws > m_best) m_best = m_ws;
        m_st = 4;
      end
      default: if (p && kc == KEY_ENTER) m_st = 0;
    endcase
    if (m_st == 0) begin m_q.delete(); m_cur = 0; end
  endfunction

  function automatic int m_mask();
    int m = 0;
    foreach (m_q[i]) m |= (1 << m_q[i]);
    return m;
  endfunction

  function automatic int m_team();
    int t = 0;
    foreach (m_q[i]) t += m_q[i] << (3 * i);
    return t;
  endfunction

  task automatic check_all();
    int scr_map[5] = '{0, 1, 1, 2, 3};
    chk("is_battle",   int'(bus.is_battle),   (m_st == 3) ? 1 : 0);
    chk("screen",      int'(bus.screen),      scr_map[m_st]);
    chk("cursor",      int'(bus.cursor),      m_cur);
    chk("picked_mask", int'(bus.picked_mask), m_mask());
    chk("slot_count",  int'(bus.slot_count),  m_q.size());
    chk("team",        int'(bus.team),        m_team());
    chk("last_result", int'(bus.last_result), m_last);
    chk("win_streak",  int'(bus.win_streak),  m_ws);
    chk("best_streak", int'(bus.best_streak), m_best);
  endtask

  task automatic cycle(input logic [7:0] kc, input logic eb, input logic res);
    @(negedge Clk);
    bus.keycode = kc; bus.end_battle = eb; bus.result = res;
    model_step(int'(kc), int'(eb), int'(res));
    @(posedge Clk);
    #1;
    check_all();
  endtask

  task automatic press(input logic [7:0] k);
    cycle(k, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    bus.keycode = '0; bus.end_battle = 1'b0; bus.result = 1'b0;
    model_reset();
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  // from TITLE with cursor 0: picks {0,1,2} and launches
  task automatic go_battle();
    press(KEY_ENTER); press(KEY_ENTER);
    press(KEY_D); press(KEY_ENTER);
    press(KEY_D); press(KEY_ENTER);
    press(KEY_ENTER);
  endtask

  task automatic run_battle(input logic res, input int exp_ws, input int exp_best);
    go_battle();
    chk("launch_is_battle", int'(bus.is_battle), 1);
    cycle(8'h00, 1'b1, res);
    chk("end_is_battle", int'(bus.is_battle), 0);
    chk("end_screen",    int'(bus.screen), 3);
    chk("end_ws",        int'(bus.win_streak), exp_ws);
    chk("end_best",      int'(bus.best_streak), exp_best);
    chk("end_last",      int'(bus.last_result), int'(res));
    press(KEY_ENTER);
  endtask

  initial begin
    logic [7:0] keys[8] = '{8'h00, KEY_W, KEY_A, KEY_S, KEY_D, KEY_ENTER, KEY_BKSP, 8'h55};
    logic [7:0] kc;

    bus.keycode = '0; bus.end_battle = 1'b0; bus.result = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge Clk) Reset_n = 1'b1;

    // held ENTER: one move to SELECT, no pick
    for (int i = 0; i < 10; i++) cycle(KEY_ENTER, 1'b0, 1'b0);
    chk("held_screen", int'(bus.screen), 1);
    chk("held_slot",   int'(bus.slot_count), 0);
    do_reset();

    tbl[0]  = '{KEY_ENTER, 1, 0, 8'h00, 0, 0};
    tbl[1]  = '{8'h00,     1, 0, 8'h00, 0, 0};
    tbl[2]  = '{KEY_D,     1, 1, 8'h00, 0, 0};
    tbl[3]  = '{8'h00,     1, 1, 8'h00, 0, 0};
    tbl[4]  = '{KEY_D,     1, 2, 8'h00, 0, 0};
    tbl[5]  = '{8'h00,     1, 2, 8'h00, 0, 0};
    tbl[6]  = '{KEY_ENTER, 1, 2, 8'h04, 1, 0};
    tbl[7]  = '{8'h00,     1, 2, 8'h04, 1, 0};
    tbl[8]  = '{KEY_S,     1, 6, 8'h04, 1, 0};
    tbl[9]  = '{8'h00,     1, 6, 8'h04, 1, 0};
    tbl[10] = '{KEY_ENTER, 1, 6, 8'h44, 2, 0};
    tbl[11] = '{8'h00,     1, 6, 8'h44, 2, 0};
    tbl[12] = '{KEY_A,     1, 5, 8'h44, 2, 0};
    tbl[13] = '{8'h00,     1, 5, 8'h44, 2, 0};
    tbl[14] = '{KEY_ENTER, 1, 5, 8'h64, 3, 0};
    tbl[15] = '{8'h00,     1, 5, 8'h64, 3, 0};
    tbl[16] = '{KEY_ENTER, 2, 5, 8'h64, 3, 1};
    foreach (tbl[i]) begin
      cycle(tbl[i].kc, 1'b0, 1'b0);
      chk("tbl_screen", int'(bus.screen),      tbl[i].scr);
      chk("tbl_cursor", int'(bus.cursor),      tbl[i].cur);
      chk("tbl_mask",   int'(bus.picked_mask), tbl[i].mask);
      chk("tbl_slot",   int'(bus.slot_count),  tbl[i].slot);
      chk("tbl_isb",    int'(bus.is_battle),   tbl[i].isb);
    end
    chk("tbl_team", int'(bus.team), 9'b101_110_010);
    // keys in BATTLE are frozen out
    press(KEY_BKSP);
    chk("battle_frozen_slot", int'(bus.slot_count), 3);

    cycle(8'h00, 1'b1, 1'b1);
    chk("b1_isb", int'(bus.is_battle), 0);
    chk("b1_ws",  int'(bus.win_streak), 1);
    cycle(8'h00, 1'b1, 1'b0);
    chk("result_ignores_pulse", int'(bus.win_streak), 1);
    press(KEY_ENTER);
    chk("title_clears_team", int'(bus.team), 0);
    run_battle(1'b1, 2, 2);
    run_battle(1'b1, 3, 3);
    run_battle(1'b0, 0, 3);

    // async reset mid-battle
    go_battle();
    chk("pre_rst_isb", int'(bus.is_battle), 1);
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_isb_async", int'(bus.is_battle), 0);
    chk("rst_best",      int'(bus.best_streak), 0);
    model_reset();
    @(negedge Clk) Reset_n = 1'b1;
    check_all();

    // grid edges and duplicate pick
    press(KEY_ENTER); press(KEY_D); press(KEY_W);
    chk("edge_w", int'(bus.cursor), 1);
    press(KEY_A); press(KEY_S); press(KEY_A);
    chk("edge_a", int'(bus.cursor), 4);
    press(KEY_ENTER); press(KEY_ENTER);
    chk("dup_slot", int'(bus.slot_count), 1);
    chk("dup_mask", int'(bus.picked_mask), 8'h10);

    // stray pulse then unwind
    cycle(8'h00, 1'b1, 1'b1);
    chk("stray_screen", int'(bus.screen), 1);
    chk("stray_ws",     int'(bus.win_streak), 0);
    press(KEY_D); press(KEY_ENTER); press(KEY_D); press(KEY_ENTER);
    chk("unwind0_mask", int'(bus.picked_mask), 8'h70);
    press(KEY_BKSP); chk("unwind1_mask", int'(bus.picked_mask), 8'h30);
    press(KEY_BKSP); chk("unwind2_mask", int'(bus.picked_mask), 8'h10);
    press(KEY_BKSP); chk("unwind3_mask", int'(bus.picked_mask), 8'h00);
    press(KEY_BKSP); chk("unwind4_screen", int'(bus.screen), 0);

    // streak saturation
    for (int i = 0; i < 256; i++) begin
      go_battle();
      cycle(8'h00, 1'b1, 1'b1);
      press(KEY_ENTER);
    end
    chk("sat_ws",   int'(bus.win_streak), 255);
    chk("sat_best", int'(bus.best_streak), 255);

    kc = 8'h00;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(1, 0) == 0) kc = keys[$urandom_range(7, 0)];
      cycle(kc, ($urandom_range(5, 0) == 0), 1'($urandom_range(1, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
